// File: rtl/fa_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional macro FA_SERIAL_OVF_EN adds a registered signed-overflow output (ovf).

module fa_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic axb;
  assign axb  = a ^ b;
  assign sum  = axb ^ cin;
  assign cout = (a & b) | (axb & cin);
endmodule

module fa_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               fa_sum, fa_cout;
  logic               last_bit;
`ifdef FA_SERIAL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  fa_structural u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef FA_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        count_d  = count_q + 1'b1;
        if (last_bit) begin
          // Result registers update only here; they hold through later operations.
          sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef FA_SERIAL_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef FA_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef FA_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
